// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the single-cycle MIPS core
//
// Contents:
//   INSTR_W                 instruction width
//   IMM_LSB/IMM_MSB         16-bit immediate field slice
//   JTARGET_MSB             top bit of the 26-bit jump target field
//   OP_BEQ/OP_J             opcode constants (used by the control benches)
//   fetch_state_e           RUN / HALT / FAULT
//   sign_ext_imm()          16 -> 32 bit sign extension
package cpu_pkg;

  localparam int INSTR_W     = 32;
  localparam int IMM_LSB     = 0;
  localparam int IMM_MSB     = 15;
  localparam int JTARGET_MSB = 25;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sign_ext_imm(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - signal bundle between the core and the PC fetch unit
//
// master: drives enable, instruction, control flags, rs value, halt request;
//         observes pc, pc_plus4, status and retired-instruction count.
// slave : the fetch unit itself.
interface pc_fetch_unit_if;
  import cpu_pkg::*;

  logic               en;
  logic [INSTR_W-1:0] instr;
  logic               branch;
  logic               zero;
  logic               jump;
  logic               jr;
  logic [31:0]        rs_data;
  logic               halt_req;

  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic               halted;
  logic               fault;
  logic [31:0]        fault_pc;
  logic [31:0]        instr_count;

  modport master (
    output en, instr, branch, zero, jump, jr, rs_data, halt_req,
    input  pc, pc_plus4, halted, fault, fault_pc, instr_count
  );

  modport slave (
    input  en, instr, branch, zero, jump, jr, rs_data, halt_req,
    output pc, pc_plus4, halted, fault, fault_pc, instr_count
  );

endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC selection
//
// Inputs : pc, instr, branch, zero, jump, jr, rs_data
// Outputs: next_pc  selected successor (jr > jump > taken beq > pc+4)
//          pc_plus4 pc+4 mod 2^32
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic [31:0]        pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  input  logic               jr,
  input  logic [31:0]        rs_data,
  output logic [31:0]        next_pc,
  output logic [31:0]        pc_plus4
);

  logic [31:0] seq;
  logic [31:0] btgt;
  logic [31:0] jtgt;
  logic        unused_opcode;

  assign seq      = pc + 32'd4;
  assign pc_plus4 = seq;

  // Branch offset is a word offset relative to the delay-free pc+4.
  assign btgt = seq + (sign_ext_imm(instr[IMM_MSB:IMM_LSB]) << 2);

  // Jump keeps the 256 MB region of pc+4, not of pc.
  assign jtgt = {seq[31:28], instr[JTARGET_MSB:0], 2'b00};

  // Opcode bits are decoded upstream by control; not needed here.
  assign unused_opcode = ^instr[INSTR_W-1:JTARGET_MSB+1];

  always_comb begin
    next_pc = seq;
    if (jr) begin
      next_pc = rs_data;
    end else if (jump) begin
      next_pc = jtgt;
    end else if (branch && zero) begin
      next_pc = btgt;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program-counter stage with run/halt/fault control
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  pc_fetch_unit_if.slave:
//          en, instr, branch, zero, jump, jr, rs_data, halt_req  (in)
//          pc, pc_plus4, halted, fault, fault_pc, instr_count    (out)
//
// Parameters:
//   RESET_PC    pc after reset
//   IMEM_DEPTH  instruction memory depth in words; legal pc is word-aligned
//               and below 4*IMEM_DEPTH
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 64
) (
  input logic           clk,
  input logic           rst,
  pc_fetch_unit_if.slave bus
);

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  fault_pc_q;
  logic [31:0]  count_q;
  logic         halted_q;
  logic         fault_q;

  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;
  logic         next_legal;

  pc_next_sel u_next_sel (
    .pc       (pc_q),
    .instr    (bus.instr),
    .branch   (bus.branch),
    .zero     (bus.zero),
    .jump     (bus.jump),
    .jr       (bus.jr),
    .rs_data  (bus.rs_data),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

  // Word index compared unsigned against the memory depth.
  assign next_legal = (next_pc[1:0] == 2'b00) &&
                      ({2'b00, next_pc[31:2]} < DEPTH_W);

  // halted/fault are kept as registered decodes of the state so they are
  // glitch-free and mutually exclusive by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= 32'h0;
      count_q    <= 32'h0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.en) begin
            if (bus.halt_req) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end else if (next_legal) begin
              pc_q <= next_pc;
              if (count_q != 32'hFFFF_FFFF) begin
                count_q <= count_q + 32'd1;
              end
            end else begin
              state_q    <= ST_FAULT;
              fault_q    <= 1'b1;
              fault_pc_q <= next_pc;
            end
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          state_q  <= ST_FAULT;
          fault_q  <= 1'b1;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.fault_pc    = fault_pc_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.en       = 1'b0;
    bus.instr    = 32'h0;
    bus.branch   = 1'b0;
    bus.zero     = 1'b0;
    bus.jump     = 1'b0;
    bus.jr       = 1'b0;
    bus.rs_data  = 32'h0;
    bus.halt_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Uses a legal jr to place pc; counts as one retired instruction.
  task automatic set_pc(input logic [31:0] a);
    idle();
    bus.en      = 1'b1;
    bus.jr      = 1'b1;
    bus.rs_data = a;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0); end
    checks++; if (bus.pc_plus4 !== 32'h4) begin failures++; $display("FAIL reset_pc_plus4 got=%h exp=%h", bus.pc_plus4, 32'h4); end
    checks++; if ({bus.halted, bus.fault} !== 2'b00) begin failures++; $display("FAIL reset_status got=%b exp=%b", {bus.halted, bus.fault}, 2'b00); end
    checks++; if (bus.fault_pc !== 32'h0) begin failures++; $display("FAIL reset_fault_pc got=%h exp=%h", bus.fault_pc, 32'h0); end
    checks++; if (bus.instr_count !== 32'h0) begin failures++; $display("FAIL reset_count got=%h exp=%h", bus.instr_count, 32'h0); end
    rst = 1'b0;
    set_pc(32'h1C);
    checks++; if (bus.pc !== 32'h1C) begin failures++; $display("FAIL setup_pc got=%h exp=%h", bus.pc, 32'h1C); end
    // Async reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL async_reset_pc got=%h exp=%h", bus.pc, 32'h0); end
    checks++; if (bus.instr_count !== 32'h0) begin failures++; $display("FAIL async_reset_count got=%h exp=%h", bus.instr_count, 32'h0); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.pc !== exp_pc[i]) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.pc, exp_pc[i]); end
    end
    checks++; if (bus.instr_count !== 32'd3) begin failures++; $display("FAIL seq_count got=%0d exp=%0d", bus.instr_count, 3); end
    checks++; if (bus.pc_plus4 !== 32'h10) begin failures++; $display("FAIL seq_pc_plus4 got=%h exp=%h", bus.pc_plus4, 32'h10); end
    idle();
  endtask

  task automatic test_beq();
    do_reset();
    set_pc(32'h14);
    bus.en = 1'b1; bus.instr = 32'h0000_0003; bus.branch = 1'b1; bus.zero = 1'b1;
    tick();
    checks++; if (bus.pc !== 32'h24) begin failures++; $display("FAIL beq_taken got=%h exp=%h", bus.pc, 32'h24); end
    set_pc(32'h14);
    bus.en = 1'b1; bus.instr = 32'h0000_0003; bus.branch = 1'b1; bus.zero = 1'b0;
    tick();
    checks++; if (bus.pc !== 32'h18) begin failures++; $display("FAIL beq_not_taken got=%h exp=%h", bus.pc, 32'h18); end
    set_pc(32'h20);
    bus.en = 1'b1; bus.instr = 32'h0000_FFFE; bus.branch = 1'b1; bus.zero = 1'b1;
    tick();
    checks++; if (bus.pc !== 32'h1C) begin failures++; $display("FAIL beq_negative got=%h exp=%h", bus.pc, 32'h1C); end
    idle();
  endtask

  task automatic test_jump_priority();
    do_reset();
    set_pc(32'h20);
    bus.en = 1'b1; bus.instr = 32'h0800_000E; bus.jump = 1'b1;
    tick();
    checks++; if (bus.pc !== 32'h38) begin failures++; $display("FAIL j_target got=%h exp=%h", bus.pc, 32'h38); end
    set_pc(32'h20);
    bus.en = 1'b1; bus.instr = 32'h0800_000E; bus.jump = 1'b1; bus.jr = 1'b1; bus.rs_data = 32'h10;
    tick();
    checks++; if (bus.pc !== 32'h10) begin failures++; $display("FAIL jr_over_j got=%h exp=%h", bus.pc, 32'h10); end
    set_pc(32'h20);
    bus.en = 1'b1; bus.instr = 32'h0800_000E; bus.jump = 1'b1; bus.jr = 1'b1;
    bus.rs_data = 32'h10; bus.branch = 1'b1; bus.zero = 1'b1;
    tick();
    checks++; if (bus.pc !== 32'h10) begin failures++; $display("FAIL jr_over_all got=%h exp=%h", bus.pc, 32'h10); end
    // j beats taken beq: btgt would be 0x24 + 0x38 = 0x5C.
    set_pc(32'h20);
    bus.en = 1'b1; bus.instr = 32'h0800_000E; bus.jump = 1'b1; bus.branch = 1'b1; bus.zero = 1'b1;
    tick();
    checks++; if (bus.pc !== 32'h38) begin failures++; $display("FAIL j_over_beq got=%h exp=%h", bus.pc, 32'h38); end
    idle();
  endtask

  task automatic test_stall();
    do_reset();
    set_pc(32'h8);
    bus.en = 1'b0; bus.instr = 32'h0800_000E; bus.jump = 1'b1; bus.halt_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.pc !== 32'h8) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, bus.pc, 32'h8); end
    end
    checks++; if (bus.instr_count !== 32'd1) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", bus.instr_count, 1); end
    checks++; if ({bus.halted, bus.fault} !== 2'b00) begin failures++; $display("FAIL stall_status got=%b exp=%b", {bus.halted, bus.fault}, 2'b00); end
    bus.en = 1'b1; bus.halt_req = 1'b0;
    tick();
    checks++; if (bus.pc !== 32'h38) begin failures++; $display("FAIL stall_release_pc got=%h exp=%h", bus.pc, 32'h38); end
    checks++; if (bus.instr_count !== 32'd2) begin failures++; $display("FAIL stall_release_count got=%0d exp=%0d", bus.instr_count, 2); end
    idle();
  endtask

  task automatic test_fault();
    do_reset();
    set_pc(32'hC);
    bus.en = 1'b1; bus.jr = 1'b1; bus.rs_data = 32'h102;
    tick();
    checks++; if (bus.fault !== 1'b1) begin failures++; $display("FAIL misalign_fault got=%b exp=%b", bus.fault, 1'b1); end
    checks++; if (bus.fault_pc !== 32'h102) begin failures++; $display("FAIL misalign_fault_pc got=%h exp=%h", bus.fault_pc, 32'h102); end
    checks++; if (bus.pc !== 32'hC) begin failures++; $display("FAIL misalign_pc got=%h exp=%h", bus.pc, 32'hC); end
    checks++; if (bus.instr_count !== 32'd1) begin failures++; $display("FAIL misalign_count got=%0d exp=%0d", bus.instr_count, 1); end
    // Absorbing: try to move, halt, and jump away.
    idle();
    bus.en = 1'b1; bus.jr = 1'b1; bus.rs_data = 32'h4; bus.halt_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if ({bus.halted, bus.fault} !== 2'b01) begin failures++; $display("FAIL fault_absorb_status got=%b exp=%b", {bus.halted, bus.fault}, 2'b01); end
    checks++; if (bus.pc !== 32'hC) begin failures++; $display("FAIL fault_absorb_pc got=%h exp=%h", bus.pc, 32'hC); end
    checks++; if (bus.fault_pc !== 32'h102) begin failures++; $display("FAIL fault_absorb_fault_pc got=%h exp=%h", bus.fault_pc, 32'h102); end
    do_reset();
    checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL fault_cleared got=%b exp=%b", bus.fault, 1'b0); end
    bus.en = 1'b1; bus.jr = 1'b1; bus.rs_data = 32'h100;
    tick();
    checks++; if (bus.fault !== 1'b1) begin failures++; $display("FAIL range_fault got=%b exp=%b", bus.fault, 1'b1); end
    checks++; if (bus.fault_pc !== 32'h100) begin failures++; $display("FAIL range_fault_pc got=%h exp=%h", bus.fault_pc, 32'h100); end
    checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL range_pc got=%h exp=%h", bus.pc, 32'h0); end
    // Last legal word, then sequential step off the end.
    do_reset();
    set_pc(32'hFC);
    checks++; if ({bus.pc, bus.fault} !== {32'hFC, 1'b0}) begin failures++; $display("FAIL last_word got=%h/%b exp=%h/0", bus.pc, bus.fault, 32'hFC); end
    bus.en = 1'b1;
    tick();
    checks++; if ({bus.fault, bus.fault_pc} !== {1'b1, 32'h100}) begin failures++; $display("FAIL seq_overrun got=%b/%h exp=1/%h", bus.fault, bus.fault_pc, 32'h100); end
    idle();
  endtask

  task automatic test_halt();
    do_reset();
    bus.en = 1'b1;
    tick();
    tick();
    bus.halt_req = 1'b1;
    tick();
    checks++; if ({bus.halted, bus.fault} !== 2'b10) begin failures++; $display("FAIL halt_status got=%b exp=%b", {bus.halted, bus.fault}, 2'b10); end
    checks++; if (bus.pc !== 32'h8) begin failures++; $display("FAIL halt_pc got=%h exp=%h", bus.pc, 32'h8); end
    checks++; if (bus.instr_count !== 32'd2) begin failures++; $display("FAIL halt_count got=%0d exp=%0d", bus.instr_count, 2); end
    bus.halt_req = 1'b0; bus.jump = 1'b1; bus.instr = 32'h0800_000E;
    for (int i = 0; i < 3; i++) tick();
    checks++; if ({bus.halted, bus.pc, bus.instr_count} !== {1'b1, 32'h8, 32'd2}) begin failures++; $display("FAIL halt_absorb got=%b/%h/%0d exp=1/%h/2", bus.halted, bus.pc, bus.instr_count, 32'h8); end
    idle();
    rst = 1'b1;
    #1;
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL halt_cleared got=%b exp=%b", bus.halted, 1'b0); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.instr_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL saturate[%0d] got=%h exp=%h", i, bus.instr_count, 32'hFFFF_FFFF); end
    end
    checks++; if (bus.pc !== 32'hC) begin failures++; $display("FAIL saturate_pc got=%h exp=%h", bus.pc, 32'hC); end
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_sequential();
    test_beq();
    test_jump_priority();
    test_stall();
    test_fault();
    test_halt();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
